// File: rtl/oled_refresh_ctrl.sv
// oled_refresh_ctrl: sole master of the OLED I2C writer; runs the init ROM, then serves full-frame refreshes.
// Optional OLED_AUTO_REFRESH_EN adds a periodic refresh timer while ready.
module oled_refresh_ctrl #(
  parameter logic [7:0] SLAVE_ADDR = 8'h78,
  parameter int COLS = 128,
  parameter int PAGES = 8,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        refresh_req,
  output logic        init_req,
  output logic        write_done,
  input  logic [23:0] init_data,
  input  logic        init_finish,
  output logic [9:0]  pix_addr,
  input  logic [7:0]  pix_data,
  output logic        i2c_req,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  output logic        ready,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_PCMD  = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;
  localparam logic [2:0] S_LOAD  = 3'd5;
  localparam logic [2:0] S_PDATA = 3'd6;

  logic [2:0] state, page;
  logic [6:0] col;
  logic [1:0] cmd_idx;
  logic [7:0] cmd_byte;
  logic pending, done_ok, last_col, last_page, auto_hit;

  // a done pulse only counts while a transaction is actually requested
  assign done_ok    = i2c_req && i2c_done;
  assign init_req   = state == S_INIT;
  assign write_done = init_req && done_ok;
  assign ready      = state == S_READY;
  assign busy       = !(state == S_IDLE || state == S_READY);
  assign pix_addr   = {page, col};
  assign last_col   = col == 7'(COLS - 1);
  assign last_page  = page == 3'(PAGES - 1);
  assign frame_done = state == S_PDATA && done_ok && last_col && last_page;
  assign cmd_byte   = cmd_idx == 2'd0 ? {5'b10110, page} : cmd_idx == 2'd1 ? 8'h00 : 8'h10;

`ifdef OLED_AUTO_REFRESH_EN
  logic [22:0] timer;
  assign auto_hit = ready && timer == 23'(REFRESH_CYCLES - 1);
  always_ff @(posedge sys_clk)
    if (rst || !ready || auto_hit) timer <= '0;
    else timer <= timer + 23'd1;
`else
  assign auto_hit = 1'b0 && (REFRESH_CYCLES > 0);
`endif

  // single-entry request latch: extra requests while busy merge into one
  always_ff @(posedge sys_clk)
    if (rst) pending <= 1'b0;
    else if (ready && (pending || refresh_req)) pending <= 1'b0;
    else if ((busy && refresh_req) || auto_hit) pending <= 1'b1;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      i2c_req  <= 1'b0;
      i2c_data <= '0;
      page     <= '0;
      col      <= '0;
      cmd_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_INIT;
        S_INIT:
          if (!i2c_req) begin
            i2c_req  <= 1'b1;
            i2c_data <= init_data;
          end else if (i2c_done) begin
            i2c_req <= 1'b0;
            if (init_finish) state <= S_READY;
          end
        S_READY:
          if (pending || refresh_req) begin
            page    <= '0;
            cmd_idx <= '0;
            state   <= S_PCMD;
          end
        S_PCMD:
          if (!i2c_req) begin
            i2c_req  <= 1'b1;
            i2c_data <= {SLAVE_ADDR, 8'h00, cmd_byte};
          end else if (i2c_done) begin
            i2c_req <= 1'b0;
            cmd_idx <= cmd_idx + 2'd1;
            if (cmd_idx == 2'd2) begin
              col   <= '0;
              state <= S_FETCH;
            end
          end
        S_FETCH: state <= S_LOAD;
        // pix_data answers the address presented during S_FETCH
        S_LOAD: begin
          i2c_req  <= 1'b1;
          i2c_data <= {SLAVE_ADDR, 8'h40, pix_data};
          state    <= S_PDATA;
        end
        S_PDATA:
          if (i2c_done) begin
            i2c_req <= 1'b0;
            if (!last_col) begin
              col   <= col + 7'd1;
              state <= S_FETCH;
            end else if (!last_page) begin
              page    <= page + 3'd1;
              cmd_idx <= '0;
              state   <= S_PCMD;
            end else state <= S_READY;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
